// File: rtl/systolic_output_deskew.sv
// Realigns diagonally skewed systolic-array result rows and writes one row per cycle into BRAM C.
// Optional build macro OUTPUT_RELU_EN clamps negative (signed) elements to zero before column masking.
module systolic_output_deskew #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 8,
    parameter int AWIDTH       = 10,
    parameter int MASK_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_row_valid,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
    input  logic [AWIDTH-1:0]              address_mat_c,
    input  logic [AWIDTH-1:0]              address_stride_c,
    input  logic [MASK_WIDTH-1:0]          validity_mask_c_rows,
    input  logic [MASK_WIDTH-1:0]          validity_mask_c_cols,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_out,
    output logic [AWIDTH-1:0]              c_addr,
    output logic                           c_wr_en,
    output logic                           busy,
    output logic                           done
);
    localparam int N  = MAT_MUL_SIZE;
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t                      r_state, w_state_nxt;
    logic [AWIDTH-1:0]           r_addr, r_stride;
    logic [MASK_WIDTH-1:0]       r_row_mask, r_col_mask;
    logic [CW-1:0]               r_acc;
    logic [SW-1:0]               r_slot;
    logic                        r_last;
    logic [N-2:0]                r_tag;
    logic [N-1:0][DWIDTH-1:0]    w_aligned, w_relu;
    logic [N*DWIDTH-1:0]         w_word;
    logic                        w_accept, w_slot;

    assign w_accept = in_row_valid && (r_state == S_CAPTURE) && (r_acc < CW'(N));
    assign w_slot   = r_tag[N-2] && (r_state == S_CAPTURE);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

    // Column k arrives k cycles late, so it waits N-1-k cycles to line up with column N-1.
    for (genvar k = 0; k < N; k++) begin : g_col
        localparam int D = N - 1 - k;
        if (D == 0) begin : g_nodly
            assign w_aligned[k] = in_data[k*DWIDTH +: DWIDTH];
        end else begin : g_dly
            logic [DWIDTH-1:0] r_pipe [D];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < D; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= in_data[k*DWIDTH +: DWIDTH];
                    for (int i = 1; i < D; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_aligned[k] = r_pipe[D-1];
        end
`ifdef OUTPUT_RELU_EN
        assign w_relu[k] = w_aligned[k][DWIDTH-1] ? '0 : w_aligned[k];
`else
        assign w_relu[k] = w_aligned[k];
`endif
        assign w_word[k*DWIDTH +: DWIDTH] = w_relu[k] & {DWIDTH{r_col_mask[k]}};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (r_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_stride   <= '0;
            r_row_mask <= '0;
            r_col_mask <= '0;
            r_acc      <= '0;
            r_slot     <= '0;
            r_last     <= 1'b0;
            r_tag      <= '0;
            c_data_out <= '0;
            c_addr     <= '0;
            c_wr_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tag[0] <= w_accept;
            for (int i = 1; i < N - 1; i++) r_tag[i] <= r_tag[i-1];
            r_last  <= w_slot && (r_slot == SW'(N - 1));
            c_wr_en <= 1'b0;
            if (start && r_state == S_IDLE) begin
                r_addr     <= address_mat_c;
                r_stride   <= address_stride_c;
                r_row_mask <= validity_mask_c_rows;
                r_col_mask <= validity_mask_c_cols;
                r_acc      <= '0;
                r_slot     <= '0;
            end
            if (w_accept) r_acc <= r_acc + CW'(1);
            // Masked rows still consume their slot: address and row index advance either way.
            if (w_slot) begin
                c_wr_en    <= r_row_mask[r_slot];
                c_data_out <= w_word;
                c_addr     <= r_addr;
                r_addr     <= r_addr + r_stride;
                r_slot     <= r_slot + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew: table of drain scenarios plus a mid-drain reset sequence.
module tb_systolic_output_deskew;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            reset, start, in_row_valid;
    logic [N*DW-1:0] in_data;
    logic [AW-1:0]   base, stride;
    logic [7:0]      rmask, cmask;
    logic [N*DW-1:0] c_data_out;
    logic [AW-1:0]   c_addr;
    logic            c_wr_en, busy, done;

    int checks = 0;
    int errors = 0;

    systolic_output_deskew #(.DWIDTH(DW), .MAT_MUL_SIZE(N), .AWIDTH(AW), .MASK_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_row_valid(in_row_valid), .in_data(in_data),
        .address_mat_c(base), .address_stride_c(stride),
        .validity_mask_c_rows(rmask), .validity_mask_c_cols(cmask),
        .c_data_out(c_data_out), .c_addr(c_addr), .c_wr_en(c_wr_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]       base;
        logic [AW-1:0]       stride;
        logic [7:0]          rmask;
        logic [7:0]          cmask;
        logic [7:0][7:0]     offs;
        int                  extra;
        logic [7:0][AW-1:0]  addr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] elem(input int r, input int k);
        if (r == 0 && k == 2) return 8'hFB;
        if (r == 0 && k == 3) return 8'h05;
        return 8'(r * 16 + k);
    endfunction

    function automatic logic [63:0] exp_word(input int r, input logic [7:0] cm);
        logic [63:0] w;
        logic [7:0]  v;
        w = '0;
        for (int k = 0; k < N; k++) begin
            v = elem(r, k);
`ifdef OUTPUT_RELU_EN
            if (v[7]) v = 8'h00;
`endif
            if (!cm[k]) v = 8'h00;
            w[k*8 +: 8] = v;
        end
        return w;
    endfunction

    // Drives one skewed row column for every row whose arrival time lines up with cycle c.
    task automatic drive_cycle(input vec_t v, input int c);
        in_row_valid = (c == v.extra);
        in_data      = {N{8'hEE}};
        for (int r = 0; r < N; r++) begin
            if (int'(v.offs[r]) == c) in_row_valid = 1'b1;
            for (int k = 0; k < N; k++)
                if (int'(v.offs[r]) + k == c) in_data[k*8 +: 8] = elem(r, k);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int last, n, sr;
        base = v.base; stride = v.stride; rmask = v.rmask; cmask = v.cmask;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d busy_after_start", id), 64'(busy), 64'd1);
        last = int'(v.offs[7]);
        for (int c = 0; c <= last + 10; c++) begin
            drive_cycle(v, c);
            start = (c == 2) || (c == last + 9);
            tick();
            n = c + 1;
            sr = -1;
            for (int r = 0; r < N; r++) if (int'(v.offs[r]) + 8 == n) sr = r;
            if (sr >= 0) begin
                chk($sformatf("v%0d wr_en n=%0d", id, n), 64'(c_wr_en), 64'(v.rmask[sr]));
                chk($sformatf("v%0d addr n=%0d", id, n), 64'(c_addr), 64'(v.addr[sr]));
                chk($sformatf("v%0d data n=%0d", id, n), c_data_out, exp_word(sr, v.cmask));
            end else begin
                chk($sformatf("v%0d idle_wr_en n=%0d", id, n), 64'(c_wr_en), 64'd0);
            end
            chk($sformatf("v%0d done n=%0d", id, n), 64'(done), 64'(n == last + 9));
            chk($sformatf("v%0d busy n=%0d", id, n), 64'(busy), 64'(n <= last + 9));
        end
        start = 1'b0;
        in_row_valid = 1'b0;
        in_data = '0;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{10'h040, 10'h008, 8'hFF, 8'hFF,
                    {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, -1,
                    {10'h078, 10'h070, 10'h068, 10'h060, 10'h058, 10'h050, 10'h048, 10'h040}};
        vecs[1] = '{10'h040, 10'h008, 8'h0F, 8'hFF,
                    {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, -1,
                    {10'h078, 10'h070, 10'h068, 10'h060, 10'h058, 10'h050, 10'h048, 10'h040}};
        vecs[2] = '{10'h040, 10'h008, 8'hFF, 8'h81,
                    {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, -1,
                    {10'h078, 10'h070, 10'h068, 10'h060, 10'h058, 10'h050, 10'h048, 10'h040}};
        vecs[3] = '{10'h3FE, 10'h001, 8'hFF, 8'hFF,
                    {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, -1,
                    {10'h005, 10'h004, 10'h003, 10'h002, 10'h001, 10'h000, 10'h3FF, 10'h3FE}};
        vecs[4] = '{10'h100, 10'h010, 8'hFF, 8'hFF,
                    {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd0}, 10,
                    {10'h170, 10'h160, 10'h150, 10'h140, 10'h130, 10'h120, 10'h110, 10'h100}};

        reset = 1'b1; start = 1'b0; in_row_valid = 1'b0; in_data = '0;
        base = '0; stride = '0; rmask = '0; cmask = '0;
        tick(); tick(); tick();
        chk("rst c_wr_en", 64'(c_wr_en), 64'd0);
        chk("rst c_addr", 64'(c_addr), 64'd0);
        chk("rst c_data_out", c_data_out, 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset lands during the 4th write of a back-to-back drain.
        v = vecs[0];
        v.base = 10'h200; v.stride = 10'h004;
        base = v.base; stride = v.stride; rmask = 8'hFF; cmask = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            drive_cycle(v, c);
            tick();
        end
        chk("mid wr_en row3", 64'(c_wr_en), 64'd1);
        chk("mid addr row3", 64'(c_addr), 64'h20C);
        chk("mid data row3", c_data_out, exp_word(3, 8'hFF));
        reset = 1'b1;
        drive_cycle(v, 11);
        tick();
        chk("after_rst wr_en", 64'(c_wr_en), 64'd0);
        chk("after_rst busy", 64'(busy), 64'd0);
        chk("after_rst done", 64'(done), 64'd0);
        reset = 1'b0;
        in_row_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk($sformatf("post_rst done c=%0d", c), 64'(done), 64'd0);
            chk($sformatf("post_rst wr_en c=%0d", c), 64'(c_wr_en), 64'd0);
        end
        run_vec(vecs[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
